// File: rtl/sig_control_pkg.sv
// sig_control_pkg
// Shared definitions for the sig_control traffic-light controller:
//   - state_e       : FSM state encodings S0..S4 (3-bit, codes 5..7 illegal)
//   - LAMP_*        : lamp-driver encodings shared by the highway and country outputs
//   - DEF_*         : default delay settings used as parameter defaults by sig_control
package sig_control_pkg;

    // S0 highway green, S1 highway yellow, S2 all red,
    // S3 country green, S4 country yellow.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_e;

    // Lamp encodings; 2'b11 is never driven.
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Default timing in clock cycles.
    localparam int DEF_Y2RDELAY        = 3;
    localparam int DEF_R2GDELAY        = 2;
    localparam int DEF_MAX_CNTRY_GREEN = 8;

endpackage

// File: rtl/sig_delay_timer.sv
// sig_delay_timer
// Loadable down counter with a done flag. Loading value N makes done_o
// go high N cycles later, so a state that loads (hold - 1) on entry and
// leaves when done_o is high occupies exactly "hold" cycles.
// Ports:
//   clock_i      rising-edge clock
//   clear_i      synchronous active-high clear, counter goes to zero
//   load_i       load strobe, takes priority over counting
//   loadValue_i  value loaded when load_i is high
//   done_o       high while the counter is zero
module sig_delay_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadValue_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load wins, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sig_control.sv
// sig_control
// Moore traffic-light controller for a highway crossing a country road.
// The highway stays green until a country-road car is sensed, then the
// lights step through highway yellow, all red, country green (while the
// car is present), country yellow and back to highway green.
// Ports:
//   clock   rising-edge clock
//   clear   synchronous active-high reset, forces S0 from any state
//   X       car present on the country road
//   hwy     highway lamp   (00 red, 01 yellow, 10 green)
//   cntry   country lamp   (same encoding)
// Optional feature, macro CNTRY_GREEN_TIMEOUT_EN: country green is cut
// off after MAX_CNTRY_GREEN cycles, and after such a forced exit the
// highway keeps green for at least MAX_CNTRY_GREEN cycles.
module sig_control
    import sig_control_pkg::*;
#(
    parameter int Y2RDELAY = DEF_Y2RDELAY,
    parameter int R2GDELAY = DEF_R2GDELAY
`ifdef CNTRY_GREEN_TIMEOUT_EN
    ,
    parameter int MAX_CNTRY_GREEN = DEF_MAX_CNTRY_GREEN
`endif
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] cntry
);

    // Timers are loaded with (hold - 1) because the load edge itself
    // is the first cycle of the new state.
    localparam logic [3:0] Y2R_LOAD = 4'(Y2RDELAY - 1);
    localparam logic [3:0] R2G_LOAD = 4'(R2GDELAY - 1);

    state_e     state_q;
    state_e     state_d;
    logic       delayLoad;
    logic [3:0] delayLoadVal;
    logic       delayDone;
    logic       acceptRequest;

    // Shared timer for the fixed-length states S1, S2 and S4.
    sig_delay_timer #(.WIDTH(4)) u_delayTimer (
        .clock_i     (clock),
        .clear_i     (clear),
        .load_i      (delayLoad),
        .loadValue_i (delayLoadVal),
        .done_o      (delayDone)
    );

`ifdef CNTRY_GREEN_TIMEOUT_EN
    localparam logic [7:0] MAXG_LOAD = 8'(MAX_CNTRY_GREEN - 1);

    logic       greenLoad;
    logic [7:0] greenLoadVal;
    logic       greenDone;
    logic       timedOut_q;
    logic       timedOut_d;

    // One timer covers both the country-green limit in S3 and the
    // minimum highway green in S0 that follows a forced exit.
    sig_delay_timer #(.WIDTH(8)) u_greenTimer (
        .clock_i     (clock),
        .clear_i     (clear),
        .load_i      (greenLoad),
        .loadValue_i (greenLoadVal),
        .done_o      (greenDone)
    );

    // A request in S0 only counts once the highway hold-off has elapsed.
    assign acceptRequest = X & greenDone;

    // Remembers that the last country green was cut short.
    always_ff @(posedge clock) begin
        if (clear) begin
            timedOut_q <= 1'b0;
        end else begin
            timedOut_q <= timedOut_d;
        end
    end
`else
    assign acceptRequest = X;
`endif

    // State register; clear overrides every transition.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, also issuing timer loads on entry to timed states.
    always_comb begin
        state_d      = state_q;
        delayLoad    = 1'b0;
        delayLoadVal = '0;
`ifdef CNTRY_GREEN_TIMEOUT_EN
        greenLoad    = 1'b0;
        greenLoadVal = '0;
        timedOut_d   = timedOut_q;
`endif
        case (state_q)
            S0: begin
                if (acceptRequest) begin
                    state_d      = S1;
                    delayLoad    = 1'b1;
                    delayLoadVal = Y2R_LOAD;
                end
            end
            S1: begin
                if (delayDone) begin
                    state_d      = S2;
                    delayLoad    = 1'b1;
                    delayLoadVal = R2G_LOAD;
                end
            end
            S2: begin
                if (delayDone) begin
                    state_d = S3;
`ifdef CNTRY_GREEN_TIMEOUT_EN
                    greenLoad    = 1'b1;
                    greenLoadVal = MAXG_LOAD;
`endif
                end
            end
            S3: begin
`ifdef CNTRY_GREEN_TIMEOUT_EN
                if (!X || greenDone) begin
                    state_d      = S4;
                    delayLoad    = 1'b1;
                    delayLoadVal = Y2R_LOAD;
                    // Leaving with the car still waiting means the limit forced it.
                    timedOut_d   = X;
                end
`else
                if (!X) begin
                    state_d      = S4;
                    delayLoad    = 1'b1;
                    delayLoadVal = Y2R_LOAD;
                end
`endif
            end
            S4: begin
                if (delayDone) begin
                    state_d = S0;
`ifdef CNTRY_GREEN_TIMEOUT_EN
                    greenLoad    = 1'b1;
                    greenLoadVal = timedOut_q ? MAXG_LOAD : 8'd0;
                    timedOut_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    // Lamp decode from the state register alone; illegal codes show all red.
    always_comb begin
        hwy   = LAMP_RED;
        cntry = LAMP_RED;
        case (state_q)
            S0:      hwy   = LAMP_GREEN;
            S1:      hwy   = LAMP_YELLOW;
            S3:      cntry = LAMP_GREEN;
            S4:      cntry = LAMP_YELLOW;
            default: begin
                hwy   = LAMP_RED;
                cntry = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_sig_control.sv
// tb_sig_control
// Self-checking bench for sig_control: a table of directed vectors for
// reset, request and release, hand-written sequences for glitches,
// mid-sequence clear and (with CNTRY_GREEN_TIMEOUT_EN) the green timeout,
// then randomized traffic compared with a phase/elapsed-time model.
module tb_sig_control;

    localparam int Y2R  = 3;
    localparam int R2G  = 2;
    localparam int MAXG = 8;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

`ifdef CNTRY_GREEN_TIMEOUT_EN
    localparam int GREEN_HOLD = 6;
`else
    localparam int GREEN_HOLD = 10;
`endif

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       X     = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;

    sig_control #(
        .Y2RDELAY        (Y2R),
        .R2GDELAY        (R2G)
`ifdef CNTRY_GREEN_TIMEOUT_EN
        ,
        .MAX_CNTRY_GREEN (MAXG)
`endif
    ) dut (
        .clock (clock),
        .clear (clear),
        .X     (X),
        .hwy   (hwy),
        .cntry (cntry)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         clr;
        bit         x;
        logic [1:0] expHwy;
        logic [1:0] expCntry;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   checkCount = 0;
    int   passCount  = 0;

    // Reference model: which light phase we are in and how many cycles
    // (counting the entry cycle) we have spent there.
    typedef enum int {HWY_GREEN, HWY_YELLOW, ALL_RED, CNTRY_GREEN, CNTRY_YELLOW} phase_e;
    phase_e mPhase   = HWY_GREEN;
    int     mElapsed = 1;
    bit     mForced  = 1'b0;
    bit     mHoldoff = 1'b0;

    task automatic enterPhase(input phase_e p);
        mPhase   = p;
        mElapsed = 1;
    endtask

    task automatic modelStep(input bit clr, input bit x);
        if (clr) begin
            enterPhase(HWY_GREEN);
            mForced  = 1'b0;
            mHoldoff = 1'b0;
        end else begin
            case (mPhase)
                HWY_GREEN: begin
                    if (x && (!mHoldoff || mElapsed >= MAXG)) enterPhase(HWY_YELLOW);
                    else mElapsed++;
                end
                HWY_YELLOW: begin
                    if (mElapsed == Y2R) enterPhase(ALL_RED);
                    else mElapsed++;
                end
                ALL_RED: begin
                    if (mElapsed == R2G) enterPhase(CNTRY_GREEN);
                    else mElapsed++;
                end
                CNTRY_GREEN: begin
                    if (!x) begin
                        enterPhase(CNTRY_YELLOW);
                    end
`ifdef CNTRY_GREEN_TIMEOUT_EN
                    else if (mElapsed == MAXG) begin
                        mForced = 1'b1;
                        enterPhase(CNTRY_YELLOW);
                    end
`endif
                    else begin
                        mElapsed++;
                    end
                end
                default: begin
                    if (mElapsed == Y2R) begin
                        mHoldoff = mForced;
                        mForced  = 1'b0;
                        enterPhase(HWY_GREEN);
                    end else begin
                        mElapsed++;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [1:0] modelHwy();
        if (mPhase == HWY_GREEN)  return GRN;
        if (mPhase == HWY_YELLOW) return YEL;
        return RED;
    endfunction

    function automatic logic [1:0] modelCntry();
        if (mPhase == CNTRY_GREEN)  return GRN;
        if (mPhase == CNTRY_YELLOW) return YEL;
        return RED;
    endfunction

    // Drive inputs on the falling edge, let one rising edge pass, and
    // advance the model; outputs are then sampled 1 time unit later.
    task automatic applyStimulus(input bit clr, input bit x);
        @(negedge clock);
        clear = clr;
        X     = x;
        @(posedge clock);
        modelStep(clr, x);
        #1;
    endtask

    task automatic checkOutput(input logic [1:0] h, input logic [1:0] c, input string name);
        checkCount++;
        if (hwy === h && cntry === c) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got hwy=%b cntry=%b, expected hwy=%b cntry=%b",
                     name, hwy, cntry, h, c);
        end
        checkCount++;
        if (hwy === RED || cntry === RED) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s_exclusive: got hwy=%b cntry=%b, expected at least one RED",
                     name, hwy, cntry);
        end
    endtask

    task automatic runExpect(input int n, input bit clr, input bit x,
                             input logic [1:0] h, input logic [1:0] c, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(clr, x);
            checkOutput(h, c, name);
        end
    endtask

    task automatic addVecs(input int n, input bit clr, input bit x,
                           input logic [1:0] h, input logic [1:0] c, input string name);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.clr      = clr;
            v.x        = x;
            v.expHwy   = h;
            v.expCntry = c;
            v.name     = name;
            vecs.push_back(v);
        end
    endtask

    initial begin
        bit xRand;

        // Reset, idle, then three identical request/release cycles.
        addVecs(5, 1'b1, 1'b0, GRN, RED, "reset");
        addVecs(15, 1'b0, 1'b0, GRN, RED, "idleAfterReset");
        for (int rep = 0; rep < 3; rep++) begin
            addVecs(Y2R, 1'b0, 1'b1, YEL, RED, "hwyYellow");
            addVecs(R2G, 1'b0, 1'b1, RED, RED, "allRed");
            addVecs(GREEN_HOLD, 1'b0, 1'b1, RED, GRN, "cntryGreen");
            addVecs(Y2R, 1'b0, 1'b0, RED, YEL, "cntryYellow");
            addVecs(4, 1'b0, 1'b0, GRN, RED, "hwyGreenAgain");
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].x);
            checkOutput(vecs[i].expHwy, vecs[i].expCntry, vecs[i].name);
        end

        // One-cycle request pulse still runs the whole sequence; a pulse
        // during all-red is ignored; country green with X low lasts one cycle.
        runExpect(1, 1'b0, 1'b1, YEL, RED, "glitchYellow");
        runExpect(Y2R - 1, 1'b0, 1'b0, YEL, RED, "glitchYellowHold");
        runExpect(1, 1'b0, 1'b0, RED, RED, "glitchAllRed");
        runExpect(1, 1'b0, 1'b1, RED, RED, "s2PulseIgnored");
        runExpect(1, 1'b0, 1'b0, RED, GRN, "glitchCntryGreen");
        runExpect(Y2R, 1'b0, 1'b0, RED, YEL, "glitchCntryYellow");
        runExpect(1, 1'b0, 1'b0, GRN, RED, "glitchBack");

        // Clear in the middle of all-red, then a fresh full-length request.
        runExpect(1, 1'b0, 1'b1, YEL, RED, "midReq");
        runExpect(Y2R - 1, 1'b0, 1'b0, YEL, RED, "midYellow");
        runExpect(1, 1'b0, 1'b0, RED, RED, "midAllRed");
        runExpect(1, 1'b1, 1'b0, GRN, RED, "midClear");
        runExpect(1, 1'b0, 1'b1, YEL, RED, "reRequest");
        runExpect(Y2R - 1, 1'b0, 1'b0, YEL, RED, "reloadYellow");
        runExpect(R2G, 1'b0, 1'b0, RED, RED, "reloadAllRed");
        runExpect(1, 1'b0, 1'b0, RED, GRN, "reloadCntryGreen");
        runExpect(Y2R, 1'b0, 1'b0, RED, YEL, "reloadCntryYellow");
        runExpect(1, 1'b0, 1'b0, GRN, RED, "reloadBack");

`ifdef CNTRY_GREEN_TIMEOUT_EN
        // X held high for 30 cycles: green cut off, then minimum highway green.
        runExpect(Y2R, 1'b0, 1'b1, YEL, RED, "toYellow");
        runExpect(R2G, 1'b0, 1'b1, RED, RED, "toAllRed");
        runExpect(MAXG, 1'b0, 1'b1, RED, GRN, "toCntryGreen");
        runExpect(Y2R, 1'b0, 1'b1, RED, YEL, "toCntryYellow");
        runExpect(MAXG, 1'b0, 1'b1, GRN, RED, "toHoldoff");
        runExpect(Y2R, 1'b0, 1'b1, YEL, RED, "toNextYellow");
        runExpect(R2G, 1'b0, 1'b1, RED, RED, "toNextAllRed");
        runExpect(1, 1'b0, 1'b1, RED, GRN, "toNextGreen");
        runExpect(Y2R, 1'b0, 1'b0, RED, YEL, "toRelease");
        runExpect(1, 1'b0, 1'b0, GRN, RED, "toBack");
`endif

        // Randomized traffic: X flips occasionally, rare clears.
        applyStimulus(1'b1, 1'b0);
        checkOutput(modelHwy(), modelCntry(), "randReset");
        xRand = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 15) xRand = ~xRand;
            applyStimulus(($urandom_range(0, 149) == 0), xRand);
            checkOutput(modelHwy(), modelCntry(), "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
